split_target_subsystem: RTL and testbench

SPLIT_TARGET_SUBSYSTEM -- requirements
Module: split_target_subsystem

---
 rtl/split_target_subsystem_if.sv | 31 +++
 rtl/split_target_subsystem.sv | 155 +++++++++++++++
 tb/tb_split_target_subsystem.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/split_target_subsystem_if.sv
// Bus-side signal bundle for the split-capable serial target.
// The slave modport is the target's view; the master modport is the bus/arbiter side.
interface split_target_subsystem_if;
    logic       decoder_valid;
    logic       bus_data_in;
    logic       bus_data_in_valid;
    logic       bus_mode;
    logic       target_rw;
    logic       split_grant;
    logic       arbiter_split_req;
    logic       split_ack;
    logic       bus_split_ack;
    logic       bus_target_ack;
    logic       bus_target_rw;
    logic       bus_target_ready;
    logic       bus_data_out;
    logic       bus_data_out_valid;
    logic [7:0] last_write;

    modport slave (
        input  decoder_valid, bus_data_in, bus_data_in_valid, bus_mode, target_rw, split_grant,
        output arbiter_split_req, split_ack, bus_split_ack, bus_target_ack, bus_target_rw,
               bus_target_ready, bus_data_out, bus_data_out_valid, last_write
    );

    modport master (
        output decoder_valid, bus_data_in, bus_data_in_valid, bus_mode, target_rw, split_grant,
        input  arbiter_split_req, split_ack, bus_split_ack, bus_target_ack, bus_target_rw,
               bus_target_ready, bus_data_out, bus_data_out_valid, last_write
    );
endinterface

// File: rtl/split_target_subsystem.sv
// Serial-bus memory target: 16-bit LSB-first address, byte writes complete in place,
// byte reads are answered as split transactions after a fixed latency and an arbiter grant.
module split_target_subsystem #(
    parameter int INTERNAL_ADDR_BITS = 12,
    parameter int READ_LATENCY       = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    split_target_subsystem_if.slave   bus
);
    localparam int DEPTH = 1 << INTERNAL_ADDR_BITS;
    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [2:0] {
        IDLE, ADDR, WDATA, WRITE, RWAIT, RREQ, SEND, ACK
    } state_e;

    state_e           state_q, state_d;
    logic [15:0]      addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [7:0]       rdata_q, rdata_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic             rw_q, rw_d;
    logic             split_ack_q, split_ack_d;
    logic [7:0]       last_write_q, last_write_d;
    logic             mem_we;
    logic             accept;

    // Contents start at zero and deliberately survive reset.
    logic [7:0] mem_q [DEPTH] = '{default: 8'h00};

    assign accept = bus.decoder_valid && bus.bus_data_in_valid;

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        bit_cnt_d    = bit_cnt_q;
        lat_cnt_d    = lat_cnt_q;
        rw_d         = rw_q;
        split_ack_d  = 1'b0;
        last_write_d = last_write_q;
        mem_we       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept && !bus.bus_mode) begin
                    addr_d    = {15'd0, bus.bus_data_in};
                    rw_d      = bus.target_rw;
                    bit_cnt_d = 4'd1;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (accept && !bus.bus_mode) begin
                    addr_d[bit_cnt_q] = bus.bus_data_in;
                    bit_cnt_d         = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd15) begin
                        bit_cnt_d = '0;
                        if (rw_q) begin
                            state_d = WDATA;
                        end else begin
                            // Fetch now so the byte is parked while the bus is released.
                            state_d     = RWAIT;
                            split_ack_d = 1'b1;
                            lat_cnt_d   = '0;
                            rdata_d     = mem_q[addr_d[INTERNAL_ADDR_BITS-1:0]];
                        end
                    end
                end
            end
            WDATA: begin
                if (accept && bus.bus_mode) begin
                    wdata_d[bit_cnt_q[2:0]] = bus.bus_data_in;
                    bit_cnt_d               = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = '0;
                        state_d   = WRITE;
                    end
                end
            end
            WRITE: begin
                mem_we       = 1'b1;
                last_write_d = wdata_q;
                state_d      = IDLE;
            end
            RWAIT: begin
                if (lat_cnt_q == LAT_W'(READ_LATENCY - 1)) begin
                    lat_cnt_d = '0;
                    state_d   = RREQ;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            RREQ: begin
                if (bus.split_grant) state_d = SEND;
            end
            SEND: begin
                rdata_d   = rdata_q >> 1;
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd7) begin
                    bit_cnt_d = '0;
                    state_d   = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            bit_cnt_q    <= '0;
            lat_cnt_q    <= '0;
            rw_q         <= 1'b0;
            split_ack_q  <= 1'b0;
            last_write_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            bit_cnt_q    <= bit_cnt_d;
            lat_cnt_q    <= lat_cnt_d;
            rw_q         <= rw_d;
            split_ack_q  <= split_ack_d;
            last_write_q <= last_write_d;
        end
    end

    // NOTE: the storage array has no reset branch; clearing it on reset would need a port per entry.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[addr_q[INTERNAL_ADDR_BITS-1:0]] <= wdata_q;
    end

    assign bus.bus_target_ready   = (state_q == IDLE);
    assign bus.arbiter_split_req  = (state_q == RREQ);
    assign bus.bus_target_ack     = (state_q == WRITE) || (state_q == ACK);
    assign bus.bus_data_out_valid = (state_q == SEND);
    assign bus.bus_data_out       = (state_q == SEND) && rdata_q[0];
    assign bus.split_ack          = split_ack_q;
    assign bus.bus_split_ack      = split_ack_q;
    assign bus.bus_target_rw      = rw_q;
    assign bus.last_write         = last_write_q;
endmodule

// File: tb/tb_split_target_subsystem.sv
// Directed bench for split_target_subsystem: writes, split reads, aliasing, deselect,
// mid-transaction hold, stray grants and reset during an outstanding read.
module tb_split_target_subsystem;
    localparam int RL = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    split_target_subsystem_if bus_if();

    split_target_subsystem #(
        .INTERNAL_ADDR_BITS (12),
        .READ_LATENCY       (RL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int total = 0;
    int bad   = 0;

    // Passive monitor: counts pulses and collects serial read data.
    int         cyc = 0, ack_cnt = 0, split_cnt = 0, bsplit_cnt = 0, split_diff = 0, nbits = 0;
    int         split_cyc = 0, req_rise_cyc = 0;
    logic       ack_rw = 1'b0, req_prev = 1'b0;
    logic [7:0] rbyte = 8'h00;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        req_prev <= bus_if.arbiter_split_req;
        if (bus_if.bus_target_ack === 1'b1) begin
            ack_cnt <= ack_cnt + 1;
            ack_rw  <= bus_if.bus_target_rw;
        end
        if (bus_if.split_ack === 1'b1) begin
            split_cnt <= split_cnt + 1;
            split_cyc <= cyc;
        end
        if (bus_if.bus_split_ack === 1'b1) bsplit_cnt <= bsplit_cnt + 1;
        if (bus_if.split_ack !== bus_if.bus_split_ack) split_diff <= split_diff + 1;
        if (bus_if.arbiter_split_req === 1'b1 && !req_prev) req_rise_cyc <= cyc;
        if (bus_if.bus_data_out_valid === 1'b1) begin
            nbits <= nbits + 1;
            rbyte <= {bus_if.bus_data_out, rbyte[7:1]};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b, input logic mode, input logic dv);
        bus_if.decoder_valid     = dv;
        bus_if.bus_data_in_valid = 1'b1;
        bus_if.bus_data_in       = b;
        bus_if.bus_mode          = mode;
        @(negedge clk);
    endtask

    task automatic release_bus();
        bus_if.bus_data_in_valid = 1'b0;
        bus_if.bus_data_in       = 1'b0;
        bus_if.bus_mode          = 1'b0;
        bus_if.decoder_valid     = 1'b1;
    endtask

    task automatic send_addr(input logic [15:0] addr, input logic rw, input logic dv);
        bus_if.target_rw = rw;
        for (int i = 0; i < 16; i++) drive_bit(addr[i], 1'b0, dv);
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [7:0] data, input logic dv);
        send_addr(addr, 1'b1, dv);
        for (int i = 0; i < 8; i++) drive_bit(data[i], 1'b1, dv);
        release_bus();
        idle(4);
    endtask

    task automatic wait_req(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (bus_if.arbiter_split_req === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic grant_pulse();
        bus_if.split_grant = 1'b1;
        @(negedge clk);
        bus_if.split_grant = 1'b0;
    endtask

    task automatic check_read(input string tag, input logic [15:0] addr, input logic [7:0] exp);
        int   a0, s0, b0, n0;
        logic seen;
        a0 = ack_cnt; s0 = split_cnt; b0 = bsplit_cnt; n0 = nbits;
        send_addr(addr, 1'b0, 1'b1);
        release_bus();
        wait_req(seen);
        check({tag, "_req_seen"}, seen, 1);
        idle(2);
        grant_pulse();
        idle(12);
        check({tag, "_data"},      rbyte, exp);
        check({tag, "_nbits"},     nbits - n0, 8);
        check({tag, "_ack"},       ack_cnt - a0, 1);
        check({tag, "_ack_rw"},    ack_rw, 0);
        check({tag, "_split"},     split_cnt - s0, 1);
        check({tag, "_bsplit"},    bsplit_cnt - b0, 1);
        check({tag, "_latency"},   req_rise_cyc - split_cyc, RL);
        check({tag, "_ready"},     bus_if.bus_target_ready, 1);
    endtask

    initial begin
        int   a0, s0, n0;
        logic seen;

        rst                      = 1'b1;
        bus_if.decoder_valid     = 1'b1;
        bus_if.bus_data_in       = 1'b0;
        bus_if.bus_data_in_valid = 1'b0;
        bus_if.bus_mode          = 1'b0;
        bus_if.target_rw         = 1'b0;
        bus_if.split_grant       = 1'b0;
        idle(2);

        check("rst_ready",     bus_if.bus_target_ready, 1);
        check("rst_last",      bus_if.last_write, 8'h00);
        check("rst_rw",        bus_if.bus_target_rw, 0);
        check("rst_ack",       bus_if.bus_target_ack, 0);
        check("rst_split",     bus_if.split_ack, 0);
        check("rst_bsplit",    bus_if.bus_split_ack, 0);
        check("rst_req",       bus_if.arbiter_split_req, 0);
        check("rst_dvalid",    bus_if.bus_data_out_valid, 0);
        check("rst_dout",      bus_if.bus_data_out, 0);
        rst = 1'b0;
        idle(2);

        // Basic write of 0xC5 to 0x8F20.
        a0 = ack_cnt; s0 = split_cnt;
        do_write(16'h8F20, 8'hC5, 1'b1);
        check("wr_ack",   ack_cnt - a0, 1);
        check("wr_ack_rw", ack_rw, 1);
        check("wr_last",  bus_if.last_write, 8'hC5);
        check("wr_split", split_cnt - s0, 0);
        check("wr_ready", bus_if.bus_target_ready, 1);

        // Split reads, including an aliased address and an unwritten location.
        check_read("rd_8f20", 16'h8F20, 8'hC5);
        check_read("rd_0f20", 16'h0F20, 8'hC5);
        check_read("rd_0001", 16'h0001, 8'h00);

        // Write with the target deselected must do nothing.
        a0 = ack_cnt; s0 = split_cnt;
        do_write(16'h0123, 8'h3A, 1'b0);
        check("desel_ack",   ack_cnt - a0, 0);
        check("desel_last",  bus_if.last_write, 8'hC5);
        check("desel_split", split_cnt - s0, 0);
        check_read("rd_0123", 16'h0123, 8'h00);

        // Deselect mid-address holds state; mode-0 bits in the data phase are ignored.
        a0 = ack_cnt;
        bus_if.target_rw = 1'b1;
        for (int i = 0; i < 8; i++) drive_bit(1'(16'h0042 >> i), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'b0, 1'b0);
        check("hold_not_ready", bus_if.bus_target_ready, 0);
        for (int i = 8; i < 16; i++) drive_bit(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            drive_bit(1'b1, 1'b0, 1'b1);
            drive_bit(1'(8'h5A >> i), 1'b1, 1'b1);
        end
        release_bus();
        idle(4);
        check("hold_ack",  ack_cnt - a0, 1);
        check("hold_last", bus_if.last_write, 8'h5A);
        check_read("rd_0042", 16'h0042, 8'h5A);

        // A stray grant while idle produces no activity.
        a0 = ack_cnt; s0 = split_cnt; n0 = nbits;
        grant_pulse();
        idle(4);
        check("stray_ack",   ack_cnt - a0, 0);
        check("stray_split", split_cnt - s0, 0);
        check("stray_nbits", nbits - n0, 0);
        check("stray_req",   bus_if.arbiter_split_req, 0);
        check("stray_ready", bus_if.bus_target_ready, 1);

        // Reset while waiting for the grant abandons the read.
        a0 = ack_cnt; n0 = nbits;
        send_addr(16'h8F20, 1'b0, 1'b1);
        release_bus();
        wait_req(seen);
        check("rstreq_seen", seen, 1);
        rst = 1'b1;
        #1;
        check("rstreq_req",   bus_if.arbiter_split_req, 0);
        check("rstreq_ready", bus_if.bus_target_ready, 1);
        check("rstreq_last",  bus_if.last_write, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        grant_pulse();
        idle(12);
        check("rstreq_nbits", nbits - n0, 0);
        check("rstreq_ack",   ack_cnt - a0, 0);

        a0 = ack_cnt;
        do_write(16'h0010, 8'h77, 1'b1);
        check("post_rst_ack",  ack_cnt - a0, 1);
        check("post_rst_last", bus_if.last_write, 8'h77);
        check_read("rd_0010", 16'h0010, 8'h77);
        check_read("rd_8f20_kept", 16'h8F20, 8'hC5);

        check("split_copy", split_diff, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
